// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: datapath width and forwarding-operand select encodings.
package cpu_pipe_pkg;

  localparam int WORD_W = 32;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'd0;
  localparam fwd_sel_t FWD_EXMEM = 2'd1;
  localparam fwd_sel_t FWD_MEMWB = 2'd2;

endpackage

// File: rtl/pipe_mux_reg_mux_n.sv
// mux_n: combinational N:1 WIDTH-bit select; an out-of-range sel yields all zeros.
import cpu_pipe_pkg::*;

module mux_n #(
  parameter int WIDTH = WORD_W,
  parameter int N     = 3,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data
);

  logic [WIDTH-1:0] w_pick [N];

  // One-hot masked inputs OR-reduced; no slot matches an out-of-range sel.
  for (genvar gi = 0; gi < N; gi++) begin : g_pick
    assign w_pick[gi] = (sel == SELW'(gi)) ? in_data[gi*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      out_data = out_data | w_pick[k];
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg: N-way select into a valid/stall/flush pipeline register, 1-cycle latency.
// Optional macro MUXREG_ERR_EN enables the sticky out-of-range select flag sel_err.
import cpu_pipe_pkg::*;

module pipe_mux_reg #(
  parameter int WIDTH  = WORD_W,
  parameter int N      = 3,
  parameter int HCNT_W = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic [HCNT_W-1:0]  hold_cnt,
  output logic               sel_err
);

  logic [WIDTH-1:0]  w_mux_data;
  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_sel;
  logic [HCNT_W-1:0] r_hold;

  mux_n #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (w_mux_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_hold  <= '0;
    end else if (stall) begin
      // Count only while a live instruction is held; saturate at all-ones.
      if (!r_valid) begin
        r_hold <= '0;
      end else if (r_hold != {HCNT_W{1'b1}}) begin
        r_hold <= r_hold + 1'b1;
      end
    end else begin
      r_hold  <= '0;
      r_valid <= in_valid;
      r_data  <= in_valid ? w_mux_data : '0;
      r_sel   <= in_valid ? sel : '0;
    end
  end

`ifdef MUXREG_ERR_EN
  logic w_sel_oor;
  logic r_sel_err;

  assign w_sel_oor = (32'(sel) >= 32'(N));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (!flush && !stall && in_valid && w_sel_oor) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign hold_cnt  = r_hold;

endmodule
